// File: rtl/markov_pkg.sv
// Shared definitions for the Markov learning engine and its pair scheduler:
// scheduler state encoding, default fragment width and ml_done handshake constants.
package markov_pkg;

  localparam int unsigned FRAG_W = 1200;

  // Engine completion handshake: active level and minimum latency after ml_start.
  localparam logic        MlDoneActive = 1'b1;
  localparam int unsigned MlDoneMinLat = 1;

  typedef enum logic [3:0] {
    StIdle,
    StRdA,
    StCapA,
    StRdB,
    StCapB,
    StKick,
    StWaitMl,
    StAdvance,
    StFinish
  } sched_state_e;

endpackage

// File: rtl/markov_sched_watchdog.sv
// Engine watchdog: counts cycles while run is high, clears whenever run drops,
// and flags expiry on the TIMEOUT_CYC-th consecutive run cycle.
module markov_sched_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CntW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      count_q <= '0;
    end else if (!expired) begin
      count_q <= count_q + CntW'(1);
    end
  end

  assign expired = run && (count_q == CntW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/markov_pair_scheduler.sv
// Feeds every adjacent fragment pair (i, i+1) from the fragment RAM into the learning engine.
// Define MARKOV_SCHED_TIMEOUT_EN to enable the engine watchdog and the sticky error flag.
module markov_pair_scheduler #(
  parameter int unsigned FRAG_W      = markov_pkg::FRAG_W,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] frag_count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [FRAG_W-1:0] mem_rd_data,
  output logic              ml_start,
  output logic [FRAG_W-1:0] ml_fragA,
  output logic [FRAG_W-1:0] ml_fragB,
  input  logic              ml_done,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pairs_done,
  output logic              error
);

  import markov_pkg::*;

  sched_state_e      state_q;
  logic [ADDR_W-1:0] n_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] pairs_q;
  logic [FRAG_W-1:0] frag_a_q;
  logic [FRAG_W-1:0] frag_b_q;

`ifdef MARKOV_SCHED_TIMEOUT_EN
  logic error_q;
  logic wd_expired;

  markov_sched_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .run    (state_q == StWaitMl),
    .expired(wd_expired)
  );

  assign error = error_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      n_q      <= '0;
      idx_q    <= '0;
      pairs_q  <= '0;
      frag_a_q <= '0;
      frag_b_q <= '0;
`ifdef MARKOV_SCHED_TIMEOUT_EN
      error_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            n_q     <= frag_count;
            idx_q   <= '0;
            pairs_q <= '0;
`ifdef MARKOV_SCHED_TIMEOUT_EN
            error_q <= 1'b0;
`endif
            state_q <= (frag_count < ADDR_W'(2)) ? StFinish : StRdA;
          end
        end
        StRdA: state_q <= StCapA;
        StCapA: begin
          frag_a_q <= mem_rd_data;
          idx_q    <= idx_q + ADDR_W'(1);
          state_q  <= StRdB;
        end
        StRdB: state_q <= StCapB;
        StCapB: begin
          frag_b_q <= mem_rd_data;
          state_q  <= StKick;
        end
        StKick: state_q <= StWaitMl;
        StWaitMl: begin
          if (ml_done == MlDoneActive) begin
            state_q <= StAdvance;
`ifdef MARKOV_SCHED_TIMEOUT_EN
          end else if (wd_expired) begin
            error_q <= 1'b1;
            state_q <= StFinish;
`endif
          end
        end
        StAdvance: begin
          pairs_q  <= pairs_q + ADDR_W'(1);
          // Second fragment of this pair is the first of the next: no re-read.
          frag_a_q <= frag_b_q;
          if (idx_q == n_q - ADDR_W'(1)) begin
            state_q <= StFinish;
          end else begin
            idx_q   <= idx_q + ADDR_W'(1);
            state_q <= StRdB;
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    ml_start  = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StRdA, StRdB: begin
        mem_rd_en = 1'b1;
        mem_addr  = idx_q;
      end
      StKick:   ml_start = 1'b1;
      StFinish: done     = 1'b1;
      default:  ;
    endcase
  end

  assign busy       = (state_q != StIdle);
  assign pairs_done = pairs_q;
  assign ml_fragA   = frag_a_q;
  assign ml_fragB   = frag_b_q;

endmodule

// File: tb/tb_markov_pair_scheduler.sv
// Randomized self-checking bench: each pass is expanded into a per-cycle expected timeline
// from the pair-walk timing rules, then the DUT is compared against it every cycle.
module tb_markov_pair_scheduler;

  localparam int FW   = 64;
  localparam int AW   = 8;
  localparam int MAXC = 2048;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] frag_count;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [FW-1:0] mem_rd_data;
  logic          ml_start;
  logic [FW-1:0] ml_fragA;
  logic [FW-1:0] ml_fragB;
  logic          ml_done;
  logic          busy;
  logic          done;
  logic [AW-1:0] pairs_done;
  logic          error;

  markov_pair_scheduler #(
    .FRAG_W     (FW),
    .ADDR_W     (AW),
    .TIMEOUT_CYC(1024)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .frag_count (frag_count),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .ml_start   (ml_start),
    .ml_fragA   (ml_fragA),
    .ml_fragB   (ml_fragB),
    .ml_done    (ml_done),
    .busy       (busy),
    .done       (done),
    .pairs_done (pairs_done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Fragment RAM: one-cycle read latency.
  logic [FW-1:0] mem [0:255];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  // Expected per-cycle timeline of the current pass (cycle 1 = first cycle after start edge).
  bit            exp_rd    [MAXC];
  int            exp_addr  [MAXC];
  bit            exp_kick  [MAXC];
  bit            exp_done  [MAXC];
  bit            exp_busy  [MAXC];
  int            exp_pairs [MAXC];
  bit            exp_err   [MAXC];
  bit            chk_frag  [MAXC];
  logic [FW-1:0] exp_fa    [MAXC];
  logic [FW-1:0] exp_fb    [MAXC];
  bit            drv_done  [MAXC];
  bit            drv_start [MAXC];
  int            len, abort_at, pc;

  int errors = 0;
  int checks = 0;
  int n_reads, n_kicks, n_done, first_kick, done_cyc, last_addr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, pc, act, expv);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".done"}, 64'(done), 64'd0);
    chk({tag, ".mem_rd_en"}, 64'(mem_rd_en), 64'd0);
    chk({tag, ".mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, ".ml_start"}, 64'(ml_start), 64'd0);
    chk({tag, ".pairs_done"}, 64'(pairs_done), 64'd0);
    chk({tag, ".error"}, 64'(error), 64'd0);
    chk({tag, ".ml_fragA"}, 64'(ml_fragA), 64'd0);
    chk({tag, ".ml_fragB"}, 64'(ml_fragB), 64'd0);
  endtask

  // lat=0 picks a random engine latency per pair; kmode: 0 none, 1 always, 2 random
  // spurious ml_done in the kick cycle; abort_pair resets during that pair's wait.
  task automatic build(input int n, input int lat, input int kmode, input int abort_pair,
                       input bit glitch, input bit tmo);
    int t, k, l;
    for (int i = 0; i < MAXC; i++) begin
      exp_rd[i] = 0; exp_addr[i] = 0; exp_kick[i] = 0; exp_done[i] = 0; exp_busy[i] = 0;
      exp_pairs[i] = 0; exp_err[i] = 0; chk_frag[i] = 0; drv_done[i] = 0; drv_start[i] = 0;
    end
    abort_at = -1;
    for (int a = 0; a < 256; a++) mem[a] = {$urandom, $urandom};
    if (n < 2) begin
      exp_done[1] = 1;
      len = 1;
    end else begin
      exp_rd[1] = 1; exp_addr[1] = 0;
      exp_rd[3] = 1; exp_addr[3] = 1;
      t = 5;
      for (int p = 0; p < n - 1; p++) begin
        exp_kick[t] = 1;
        if (kmode == 1 || (kmode == 2 && $urandom_range(1, 0) == 1)) drv_done[t] = 1;
        if (tmo) begin
`ifdef MARKOV_SCHED_TIMEOUT_EN
          len = t + 1025;
          exp_done[len] = 1;
          for (int c = len; c < MAXC; c++) exp_err[c] = 1;
`else
          abort_at = t + 1195;
          len = abort_at;
`endif
          for (int c = t; c <= len; c++) begin
            chk_frag[c] = 1; exp_fa[c] = mem[0]; exp_fb[c] = mem[1];
          end
          break;
        end
        l = (lat > 0) ? lat : int'($urandom_range(4, 1));
        k = t + l;
        drv_done[k] = 1;
        for (int c = t; c <= k + 1; c++) begin
          chk_frag[c] = 1; exp_fa[c] = mem[p]; exp_fb[c] = mem[p+1];
        end
        if (glitch && p == 0) drv_start[t+1] = 1;
        if (p == abort_pair) begin
          abort_at = t + 1;
          drv_done[k] = 0;
          len = abort_at;
          break;
        end
        for (int c = k + 2; c < MAXC; c++) exp_pairs[c] = p + 1;
        if (p == n - 2) begin
          exp_done[k+2] = 1;
          len = k + 2;
        end else begin
          exp_rd[k+2] = 1; exp_addr[k+2] = p + 2;
          t = k + 4;
        end
      end
    end
    for (int c = 1; c <= len; c++) exp_busy[c] = 1;
  endtask

  // Per-cycle compare loop for one pass, plus the idle cycle that follows it.
  task automatic run_pass(input int n, input int lat, input int kmode, input int abort_pair,
                          input bit glitch, input bit tmo);
    build(n, lat, kmode, abort_pair, glitch, tmo);
    n_reads = 0; n_kicks = 0; n_done = 0; first_kick = -1; done_cyc = -1; last_addr = -1;
    @(negedge clk);
    start = 1'b1;
    frag_count = AW'(n);
    for (pc = 1; pc <= len + 1; pc++) begin
      @(negedge clk);
      if (abort_at >= 0 && pc == abort_at + 1) begin
        chk_reset_values("after_reset");
        reset = 1'b0;
        break;
      end
      frag_count = AW'($urandom);
      chk("busy", 64'(busy), 64'(exp_busy[pc]));
      chk("done", 64'(done), 64'(exp_done[pc]));
      chk("mem_rd_en", 64'(mem_rd_en), 64'(exp_rd[pc]));
      chk("ml_start", 64'(ml_start), 64'(exp_kick[pc]));
      chk("pairs_done", 64'(pairs_done), 64'(exp_pairs[pc]));
      chk("error", 64'(error), 64'(exp_err[pc]));
      if (exp_rd[pc]) chk("mem_addr", 64'(mem_addr), 64'(exp_addr[pc]));
      if (chk_frag[pc]) begin
        chk("ml_fragA", 64'(ml_fragA), 64'(exp_fa[pc]));
        chk("ml_fragB", 64'(ml_fragB), 64'(exp_fb[pc]));
      end
      if (mem_rd_en) begin n_reads++; last_addr = int'(mem_addr); end
      if (ml_start) begin n_kicks++; if (first_kick < 0) first_kick = pc; end
      if (done) begin n_done++; done_cyc = pc; end
      ml_done = drv_done[pc];
      start   = drv_start[pc];
      reset   = (pc == abort_at);
    end
    ml_done = 1'b0;
    start   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; frag_count = '0; ml_done = 1'b0; pc = 0;
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("idle.busy", 64'(busy), 64'd0);

    // N=4, engine latency 3: hand-derived timeline pins the model.
    run_pass(4, 3, 0, -1, 1'b0, 1'b0);
    chk("n4.model_len", 64'(len), 64'd24);
    chk("n4.reads", 64'(n_reads), 64'd4);
    chk("n4.kicks", 64'(n_kicks), 64'd3);
    chk("n4.first_kick", 64'(first_kick), 64'd5);
    chk("n4.done_cycle", 64'(done_cyc), 64'd24);
    chk("n4.done_pulses", 64'(n_done), 64'd1);
    chk("n4.pairs", 64'(pairs_done), 64'd3);

    for (int n = 1; n >= 0; n--) begin
      run_pass(n, 0, 2, -1, 1'b0, 1'b0);
      chk("short.reads", 64'(n_reads), 64'd0);
      chk("short.kicks", 64'(n_kicks), 64'd0);
      chk("short.done_cycle", 64'(done_cyc), 64'd1);
      chk("short.pairs", 64'(pairs_done), 64'd0);
    end

    run_pass(3, 0, 2, -1, 1'b1, 1'b0);
    chk("glitch.pairs", 64'(pairs_done), 64'd2);
    chk("glitch.done_pulses", 64'(n_done), 64'd1);

    run_pass(3, 0, 2, 1, 1'b0, 1'b0);
    chk("abort.done_pulses", 64'(n_done), 64'd0);
    run_pass(4, 0, 2, -1, 1'b0, 1'b0);
    chk("after_abort.pairs", 64'(pairs_done), 64'd3);

    run_pass(2, 0, 1, -1, 1'b0, 1'b1);
    chk("timeout.kicks", 64'(n_kicks), 64'd1);
`ifdef MARKOV_SCHED_TIMEOUT_EN
    chk("timeout.done_cycle", 64'(done_cyc), 64'd1030);
    chk("timeout.error", 64'(error), 64'd1);
`else
    chk("timeout.done_pulses", 64'(n_done), 64'd0);
`endif
    run_pass(2, 0, 2, -1, 1'b0, 1'b0);
    chk("after_timeout.error", 64'(error), 64'd0);

    run_pass(255, 1, 2, -1, 1'b0, 1'b0);
    chk("n255.last_addr", 64'(last_addr), 64'd254);
    chk("n255.pairs", 64'(pairs_done), 64'd254);
    chk("n255.reads", 64'(n_reads), 64'd255);
    chk("n255.kicks", 64'(n_kicks), 64'd254);

    for (int i = 0; i < 20; i++) begin
      run_pass(int'($urandom_range(12, 0)), 0, 2, -1, 1'($urandom_range(1, 0)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
